// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: stall polarity, the
// default stall-vector width, stage indices and the per-edge action encoding.
package pipe_pkg;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   localparam int STALL_W = 6;

   localparam int IF_ID  = 1;
   localparam int ID_EX  = 2;
   localparam int EX_MEM = 3;
   localparam int MEM_WB = 4;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // One action is applied per rising edge, listed here in priority order.
   typedef enum logic [2:0] {
      ACT_RESET   = 3'd0,
      ACT_FLUSH   = 3'd1,
      ACT_BUBBLE  = 3'd2,
      ACT_HOLD    = 3'd3,
      ACT_ILLEGAL = 3'd4,
      ACT_ADVANCE = 3'd5
   } action_t;

   function automatic action_t decode_action(input logic rst, input logic fl,
                                             input logic s_cur, input logic s_nxt);
      action_t act;
      act = ACT_ADVANCE;
      if (rst)
         act = ACT_RESET;
      else if (fl)
         act = ACT_FLUSH;
      else if (s_cur == STOP && s_nxt == NOSTOP)
         act = ACT_BUBBLE;
      else if (s_cur == STOP && s_nxt == STOP)
         act = ACT_HOLD;
      else if (s_cur == NOSTOP && s_nxt == STOP)
         act = ACT_ILLEGAL;
      return act;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid bit, bubble insertion and flush.
// Define PIPE_STAGE_PERF_EN to add saturating hold/bubble performance counters.
module pipe_stage_reg #(
   parameter int                 WIDTH   = 32,
   parameter int                 STALL_W = 6,
   parameter int                 STAGE   = 3,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
   parameter int                 CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               i_valid,
   input  logic [WIDTH-1:0]   i_data,
   output logic               o_valid,
   output logic [WIDTH-1:0]   o_data,
   output logic               o_bubble
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]   o_hold_cnt,
   output logic [CNT_W-1:0]   o_bubble_cnt
`endif
);

   import pipe_pkg::*;

   logic    w_s_cur;
   logic    w_s_nxt;
   action_t w_action;

   if (WIDTH < 1) begin : g_bad_width
      $error("pipe_stage_reg: WIDTH must be at least 1");
   end
   if (STAGE < 0 || STAGE >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE must lie inside the stall vector");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("pipe_stage_reg: CNT_W must be at least 1");
   end

   assign w_s_cur = stall[STAGE];

   // The last stage has no downstream stall bit; it always sees NOSTOP there.
   if (STAGE == STALL_W - 1) begin : g_last_stage
      assign w_s_nxt = NOSTOP;
   end else begin : g_mid_stage
      assign w_s_nxt = stall[STAGE+1];
   end

   always_comb begin
      w_action = decode_action(reset, flush, w_s_cur, w_s_nxt);
   end

   always_ff @(posedge clk) begin
      case (w_action)
         ACT_RESET: begin
            o_valid  <= 1'b0;
            o_data   <= RST_VAL;
            o_bubble <= 1'b0;
         end
         ACT_FLUSH, ACT_BUBBLE: begin
            o_valid  <= 1'b0;
            o_data   <= RST_VAL;
            o_bubble <= 1'b1;
         end
         ACT_ADVANCE: begin
            // Invalid upstream words pass through untouched; o_valid gates them.
            o_valid  <= i_valid;
            o_data   <= i_data;
            o_bubble <= 1'b0;
         end
         default: begin
            o_valid  <= o_valid;
            o_data   <= o_data;
            o_bubble <= o_bubble;
         end
      endcase
   end

`ifdef PIPE_STAGE_PERF_EN
   logic w_hold_inc;
   logic w_bubble_inc;

   assign w_hold_inc   = (w_action == ACT_HOLD) || (w_action == ACT_ILLEGAL);
   assign w_bubble_inc = (w_action == ACT_BUBBLE);

   sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_hold_inc),
      .count (o_hold_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_bubble_inc),
      .count (o_bubble_cnt)
   );
`endif

`ifndef SYNTHESIS
   // A monotonic stall vector never stalls downstream while this stage runs.
   always_ff @(posedge clk) begin
      if (w_action == ACT_ILLEGAL)
         $warning("pipe_stage_reg: illegal stall vector %b at stage %0d", stall, STAGE);
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg: three instances share one
// stimulus stream (STAGE=3 wide counter, STAGE=3 2-bit counter, STAGE=5).
module tb_pipe_stage_reg;

  localparam int EXP_W = 37;

  logic       clk;
  logic       reset;
  logic [5:0] stall;
  logic       flush;
  logic       i_valid;
  logic [7:0] i_data;

  logic       a_valid, b_valid, c_valid;
  logic [7:0] a_data, b_data, c_data;
  logic       a_bubble, b_bubble, c_bubble;
`ifdef PIPE_STAGE_PERF_EN
  logic [7:0] a_hold_cnt, a_bubble_cnt, c_hold_cnt, c_bubble_cnt;
  logic [1:0] b_hold_cnt, b_bubble_cnt;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int checks;
  int errors;
  bit stim_done;

  pipe_stage_reg #(.WIDTH(8), .STALL_W(6), .STAGE(3), .RST_VAL(8'hA5), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(a_valid), .o_data(a_data), .o_bubble(a_bubble)
`ifdef PIPE_STAGE_PERF_EN
    , .o_hold_cnt(a_hold_cnt), .o_bubble_cnt(a_bubble_cnt)
`endif
  );

  pipe_stage_reg #(.WIDTH(8), .STALL_W(6), .STAGE(3), .RST_VAL(8'hA5), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(b_valid), .o_data(b_data), .o_bubble(b_bubble)
`ifdef PIPE_STAGE_PERF_EN
    , .o_hold_cnt(b_hold_cnt), .o_bubble_cnt(b_bubble_cnt)
`endif
  );

  pipe_stage_reg #(.WIDTH(8), .STALL_W(6), .STAGE(5), .RST_VAL(8'hA5), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_data(i_data),
    .o_valid(c_valid), .o_data(c_data), .o_bubble(c_bubble)
`ifdef PIPE_STAGE_PERF_EN
    , .o_hold_cnt(c_hold_cnt), .o_bubble_cnt(c_bubble_cnt)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver: one call = one clock edge of stimulus plus the expected result
  // after that edge. Expected word: a_v a_b a_d a_h a_bc b_h c_b c_bc.
  task automatic drive(input logic rst, input logic fl, input logic [5:0] st,
                       input logic iv, input logic [7:0] d,
                       input logic ev, input logic eb, input logic [7:0] ed,
                       input logic [7:0] eh, input logic [7:0] ebc,
                       input logic [1:0] ebh, input logic ecb, input logic [7:0] ecbc);
    @(negedge clk);
    reset   = rst;
    flush   = fl;
    stall   = st;
    i_valid = iv;
    i_data  = d;
    exp_q.push_back({ev, eb, ed, eh, ebc, ebh, ecb, ecbc});
  endtask

  // Monitor: samples just after each rising edge and pops one expectation.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_valid",  {7'd0, a_valid},  {7'd0, e[36]});
        chk("a_bubble", {7'd0, a_bubble}, {7'd0, e[35]});
        chk("a_data",   a_data,           e[34:27]);
        chk("b_data",   b_data,           e[34:27]);
        chk("c_bubble", {7'd0, c_bubble}, {7'd0, e[8]});
`ifdef PIPE_STAGE_PERF_EN
        chk("a_hold_cnt",   a_hold_cnt,          e[26:19]);
        chk("a_bubble_cnt", a_bubble_cnt,        e[18:11]);
        chk("b_hold_cnt",   {6'd0, b_hold_cnt},  {6'd0, e[10:9]});
        chk("c_bubble_cnt", c_bubble_cnt,        e[7:0]);
`endif
      end
    end
  end

  initial begin
    int budget;
    checks = 0;
    errors = 0;
    stim_done = 1'b0;
    reset = 1'b1; flush = 1'b0; stall = 6'b0; i_valid = 1'b1; i_data = 8'h3C;

    //    rst fl  stall      iv  data   ev  eb  edata  hold  bcnt  bh    cb  cbcnt
    // reset for two cycles
    drive(1, 0, 6'b000000, 1, 8'h3C, 0, 0, 8'hA5, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    drive(1, 0, 6'b000000, 1, 8'h3C, 0, 0, 8'hA5, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    // advance
    drive(0, 0, 6'b000000, 1, 8'h11, 1, 0, 8'h11, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    drive(0, 0, 6'b000000, 1, 8'h22, 1, 0, 8'h22, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    drive(0, 0, 6'b000000, 1, 8'h33, 1, 0, 8'h33, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    // single-cycle bubble, next word follows immediately
    drive(0, 0, 6'b001111, 1, 8'h44, 0, 1, 8'hA5, 8'd0, 8'd1, 2'd0, 0, 8'd0);
    drive(0, 0, 6'b000000, 1, 8'h55, 1, 0, 8'h55, 8'd0, 8'd1, 2'd0, 0, 8'd0);
    drive(0, 0, 6'b000000, 1, 8'h22, 1, 0, 8'h22, 8'd0, 8'd1, 2'd0, 0, 8'd0);
    // hold three cycles
    drive(0, 0, 6'b011111, 1, 8'h66, 1, 0, 8'h22, 8'd1, 8'd1, 2'd1, 0, 8'd0);
    drive(0, 0, 6'b011111, 1, 8'h66, 1, 0, 8'h22, 8'd2, 8'd1, 2'd2, 0, 8'd0);
    drive(0, 0, 6'b011111, 1, 8'h66, 1, 0, 8'h22, 8'd3, 8'd1, 2'd3, 0, 8'd0);
    // flush beats hold; reset beats flush
    drive(0, 1, 6'b011111, 1, 8'h66, 0, 1, 8'hA5, 8'd3, 8'd1, 2'd3, 1, 8'd0);
    drive(1, 1, 6'b011111, 1, 8'h66, 0, 0, 8'hA5, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    // invalid word passes through unchanged
    drive(0, 0, 6'b000000, 0, 8'h77, 0, 0, 8'h77, 8'd0, 8'd0, 2'd0, 0, 8'd0);
    // illegal vector at STAGE=3 behaves as hold
    drive(0, 0, 6'b010000, 1, 8'h88, 0, 0, 8'h77, 8'd1, 8'd0, 2'd1, 0, 8'd0);
    // full stall: STAGE=3 holds, STAGE=5 bubbles every cycle; 2-bit counter saturates
    drive(0, 0, 6'b111111, 1, 8'h99, 0, 0, 8'h77, 8'd2, 8'd0, 2'd2, 1, 8'd1);
    drive(0, 0, 6'b111111, 1, 8'h99, 0, 0, 8'h77, 8'd3, 8'd0, 2'd3, 1, 8'd2);
    drive(0, 0, 6'b111111, 1, 8'h99, 0, 0, 8'h77, 8'd4, 8'd0, 2'd3, 1, 8'd3);
    drive(0, 0, 6'b111111, 1, 8'h99, 0, 0, 8'h77, 8'd5, 8'd0, 2'd3, 1, 8'd4);
    drive(0, 0, 6'b111111, 1, 8'h99, 0, 0, 8'h77, 8'd6, 8'd0, 2'd3, 1, 8'd5);
    drive(0, 0, 6'b000000, 1, 8'h9A, 1, 0, 8'h9A, 8'd6, 8'd0, 2'd3, 0, 8'd5);

    @(negedge clk);
    stall = 6'b0; flush = 1'b0; i_valid = 1'b0;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
